// File: rtl/clint_trap_ctrl_if.sv
// ============================================================================
// Module  : clint_trap_ctrl_if
// Brief   : CSR clint port between the trap controller and the CSR file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface clint_trap_ctrl_if;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic [31:0] csr_mstatus;
  logic        we_o;
  logic [31:0] waddr_o;
  logic [31:0] data_o;

  // Trap controller side
  modport master (
    input  csr_mtvec, csr_mepc, csr_mstatus,
    output we_o, waddr_o, data_o
  );

  // CSR register file side
  modport slave (
    output csr_mtvec, csr_mepc, csr_mstatus,
    input  we_o, waddr_o, data_o
  );
endinterface

`default_nettype wire

// File: rtl/clint_trap_ctrl.sv
// ============================================================================
// Module  : clint_trap_ctrl
// Brief   : Core-local trap controller sequencing mepc/mcause/mstatus writes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module clint_trap_ctrl #(
  parameter logic [31:0] INT_CAUSE    = 32'h8000_0007,
  parameter logic [31:0] ECALL_CAUSE  = 32'd11,
  parameter logic [31:0] EBREAK_CAUSE = 32'd3
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic [31:0] inst_i,
  input  wire logic [31:0] inst_addr_i,
  input  wire logic        jump_flag_i,
  input  wire logic [31:0] jump_addr_i,
  input  wire logic        hold_flag_i,
  input  wire logic [7:0]  int_flag_i,
  input  wire logic        global_int_en_i,
  clint_trap_ctrl_if.master csr_bus,
  output      logic        hold_flag_o,
  output      logic        int_assert_o,
  output      logic [31:0] int_addr_o
);

  localparam logic [31:0] C_INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] C_INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] C_INST_MRET   = 32'h3020_0073;
  localparam logic [31:0] C_ADDR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] C_ADDR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] C_ADDR_MCAUSE  = 32'h0000_0342;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    W_MEPC      = 3'd1,
    W_MCAUSE    = 3'd2,
    W_MSTATUS   = 3'd3,
    ASSERT      = 3'd4,
    W_MRET      = 3'd5,
    ASSERT_MRET = 3'd6
  } state_t;

  state_t      r_state;
  logic [31:0] r_cause;
  logic        r_we;
  logic [31:0] r_waddr;
  logic [31:0] r_data;

  logic        w_ecall;
  logic        w_ebreak;
  logic        w_mret;
  logic        w_sync;
  logic        w_async;
  logic        w_accept;
  logic [31:0] w_mstatus_trap;
  logic [31:0] w_mstatus_mret;

  assign w_ecall  = (inst_i == C_INST_ECALL);
  assign w_ebreak = (inst_i == C_INST_EBREAK);
  assign w_mret   = (inst_i == C_INST_MRET);
  assign w_sync   = w_ecall | w_ebreak;
  assign w_async  = global_int_en_i & (|int_flag_i);
  assign w_accept = (r_state == IDLE) & ~hold_flag_i & (w_sync | w_mret | w_async);

  // Entry saves MIE into MPIE and clears MIE; return restores MIE and sets MPIE.
  assign w_mstatus_trap = {csr_bus.csr_mstatus[31:8], csr_bus.csr_mstatus[3],
                           csr_bus.csr_mstatus[6:4], 1'b0, csr_bus.csr_mstatus[2:0]};
  assign w_mstatus_mret = {csr_bus.csr_mstatus[31:8], 1'b1,
                           csr_bus.csr_mstatus[6:4], csr_bus.csr_mstatus[7],
                           csr_bus.csr_mstatus[2:0]};

  // Stall must be visible in the detection cycle, so it bypasses the FSM register.
  assign hold_flag_o = rst & ((r_state != IDLE) | w_accept);

  assign csr_bus.we_o    = r_we;
  assign csr_bus.waddr_o = r_waddr;
  assign csr_bus.data_o  = r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cause      <= '0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_data       <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          int_assert_o <= 1'b0;
          r_we         <= 1'b0;
          if (w_accept) begin
            if (w_sync) begin
              r_cause <= w_ecall ? ECALL_CAUSE : EBREAK_CAUSE;
              r_we    <= 1'b1;
              r_waddr <= C_ADDR_MEPC;
              r_data  <= inst_addr_i;
              r_state <= W_MEPC;
            end else if (w_mret) begin
              r_we    <= 1'b1;
              r_waddr <= C_ADDR_MSTATUS;
              r_data  <= w_mstatus_mret;
              r_state <= W_MRET;
            end else begin
              r_cause <= INT_CAUSE;
              r_we    <= 1'b1;
              r_waddr <= C_ADDR_MEPC;
              r_data  <= jump_flag_i ? jump_addr_i : inst_addr_i;
              r_state <= W_MEPC;
            end
          end
        end
        W_MEPC: begin
          r_we    <= 1'b1;
          r_waddr <= C_ADDR_MCAUSE;
          r_data  <= r_cause;
          r_state <= W_MCAUSE;
        end
        W_MCAUSE: begin
          r_we    <= 1'b1;
          r_waddr <= C_ADDR_MSTATUS;
          r_data  <= w_mstatus_trap;
          r_state <= W_MSTATUS;
        end
        W_MSTATUS: begin
          r_we         <= 1'b0;
          int_assert_o <= 1'b1;
          int_addr_o   <= csr_bus.csr_mtvec;
          r_state      <= ASSERT;
        end
        ASSERT: begin
          int_assert_o <= 1'b0;
          r_state      <= IDLE;
        end
        W_MRET: begin
          r_we         <= 1'b0;
          int_assert_o <= 1'b1;
          int_addr_o   <= csr_bus.csr_mepc;
          r_state      <= ASSERT_MRET;
        end
        ASSERT_MRET: begin
          int_assert_o <= 1'b0;
          r_state      <= IDLE;
        end
        default: begin
          r_we         <= 1'b0;
          int_assert_o <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clint_trap_ctrl.sv
// ============================================================================
// Module  : tb_clint_trap_ctrl
// Brief   : Directed self-checking bench for clint_trap_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clint_trap_ctrl;

  localparam logic [31:0] C_ECALL  = 32'h0000_0073;
  localparam logic [31:0] C_EBREAK = 32'h0010_0073;
  localparam logic [31:0] C_MRET   = 32'h3020_0073;
  localparam logic [31:0] C_NOP    = 32'h0000_0013;
  localparam logic [31:0] C_INT    = 32'h8000_0007;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst_i = C_NOP;
  logic [31:0] inst_addr_i = '0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        hold_flag_i = 1'b0;
  logic [7:0]  int_flag_i = '0;
  logic        global_int_en_i = 1'b0;
  logic        hold_flag_o;
  logic        int_assert_o;
  logic [31:0] int_addr_o;

  int n_checks = 0;
  int n_fail   = 0;

  clint_trap_ctrl_if bus ();

  clint_trap_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .inst_i          (inst_i),
    .inst_addr_i     (inst_addr_i),
    .jump_flag_i     (jump_flag_i),
    .jump_addr_i     (jump_addr_i),
    .hold_flag_i     (hold_flag_i),
    .int_flag_i      (int_flag_i),
    .global_int_en_i (global_int_en_i),
    .csr_bus         (bus),
    .hold_flag_o     (hold_flag_o),
    .int_assert_o    (int_assert_o),
    .int_addr_o      (int_addr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs requesting a trap are already applied; walks T..T+5 and mimics the CSR file on mstatus.
  task automatic run_entry(input logic [31:0] epc, input logic [31:0] cause,
                           input logic [31:0] mst, input logic [31:0] vec);
    #1;
    check("hold_T", hold_flag_o, 1);
    step();
    inst_i = C_NOP;
    check("mepc_we", bus.we_o, 1);
    check("mepc_addr", bus.waddr_o, 32'h341);
    check("mepc_data", bus.data_o, epc);
    check("hold_T1", hold_flag_o, 1);
    step();
    check("mcause_we", bus.we_o, 1);
    check("mcause_addr", bus.waddr_o, 32'h342);
    check("mcause_data", bus.data_o, cause);
    check("hold_T2", hold_flag_o, 1);
    step();
    check("mstatus_we", bus.we_o, 1);
    check("mstatus_addr", bus.waddr_o, 32'h300);
    check("mstatus_data", bus.data_o, mst);
    check("hold_T3", hold_flag_o, 1);
    bus.csr_mstatus = mst;
    global_int_en_i = mst[3];
    step();
    check("assert_we", bus.we_o, 0);
    check("assert_strobe", int_assert_o, 1);
    check("assert_addr", int_addr_o, vec);
    check("hold_T4", hold_flag_o, 1);
    step();
    check("post_strobe", int_assert_o, 0);
    check("post_addr_hold", int_addr_o, vec);
  endtask

  initial begin
    bus.csr_mtvec   = 32'h0000_0800;
    bus.csr_mepc    = '0;
    bus.csr_mstatus = 32'h0000_0008;

    // Reset state, with an ecall present that must not raise a stall
    inst_i = C_ECALL;
    #12;
    check("rst_we", bus.we_o, 0);
    check("rst_waddr", bus.waddr_o, 0);
    check("rst_data", bus.data_o, 0);
    check("rst_assert", int_assert_o, 0);
    check("rst_addr", int_addr_o, 0);
    check("rst_hold", hold_flag_o, 0);
    inst_i = C_NOP;
    step();
    rst = 1'b1;
    step();

    // 1: ecall
    inst_i = C_ECALL;
    inst_addr_i = 32'h0000_0100;
    bus.csr_mstatus = 32'h0000_0008;
    run_entry(32'h100, 32'd11, 32'h80, 32'h800);
    check("ecall_release", hold_flag_o, 0);

    // 2: async interrupt with ex redirect in flight
    int_flag_i = 8'h01;
    global_int_en_i = 1'b1;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0200;
    inst_addr_i = 32'h0000_0300;
    bus.csr_mstatus = 32'h0000_0008;
    run_entry(32'h200, C_INT, 32'h80, 32'h800);
    jump_flag_i = 1'b0;
    global_int_en_i = 1'b0;
    #1;
    check("int_masked_hold", hold_flag_o, 0);
    step();
    check("int_masked_we", bus.we_o, 0);
    check("int_masked_waddr_hold", bus.waddr_o, 32'h300);
    step();
    check("int_masked_we2", bus.we_o, 0);
    check("int_masked_assert", int_assert_o, 0);
    int_flag_i = 8'h00;

    // 3: mret
    bus.csr_mstatus = 32'h0000_0080;
    bus.csr_mepc = 32'h0000_0104;
    inst_i = C_MRET;
    #1;
    check("mret_hold_T", hold_flag_o, 1);
    step();
    inst_i = C_NOP;
    check("mret_we", bus.we_o, 1);
    check("mret_addr", bus.waddr_o, 32'h300);
    check("mret_data", bus.data_o, 32'h88);
    step();
    check("mret_we_off", bus.we_o, 0);
    check("mret_strobe", int_assert_o, 1);
    check("mret_target", int_addr_o, 32'h104);
    check("mret_hold_T2", hold_flag_o, 1);
    step();
    check("mret_idle_strobe", int_assert_o, 0);
    check("mret_idle_hold", hold_flag_o, 0);

    // 4a: ebreak and interrupt together; sync wins
    bus.csr_mstatus = 32'h0000_0008;
    global_int_en_i = 1'b1;
    int_flag_i = 8'h01;
    inst_i = C_EBREAK;
    inst_addr_i = 32'h0000_0400;
    run_entry(32'h400, 32'd3, 32'h80, 32'h800);
    check("ebreak_mie_blocks", hold_flag_o, 0);
    int_flag_i = 8'h00;

    // 4b: ecall held off by external stall
    hold_flag_i = 1'b1;
    inst_i = C_ECALL;
    inst_addr_i = 32'h0000_0500;
    bus.csr_mstatus = 32'h0000_0008;
    #1;
    check("held_hold", hold_flag_o, 0);
    step();
    check("held_we", bus.we_o, 0);
    step();
    check("held_we2", bus.we_o, 0);
    hold_flag_i = 1'b0;
    run_entry(32'h500, 32'd11, 32'h80, 32'h800);

    // 5: reset during W_MCAUSE
    bus.csr_mstatus = 32'h0000_0008;
    inst_i = C_ECALL;
    inst_addr_i = 32'h0000_0600;
    step();
    inst_i = C_NOP;
    check("rst5_mepc_we", bus.we_o, 1);
    step();
    check("rst5_mcause_addr", bus.waddr_o, 32'h342);
    #2;
    rst = 1'b0;
    #1;
    check("rst5_we", bus.we_o, 0);
    check("rst5_waddr", bus.waddr_o, 0);
    check("rst5_data", bus.data_o, 0);
    check("rst5_hold", hold_flag_o, 0);
    step();
    check("rst5_assert", int_assert_o, 0);
    rst = 1'b1;
    step();
    check("rst5_after_we", bus.we_o, 0);
    check("rst5_after_assert", int_assert_o, 0);
    inst_i = C_ECALL;
    inst_addr_i = 32'h0000_0700;
    run_entry(32'h700, 32'd11, 32'h80, 32'h800);

    // 6: interrupt held through handler, re-entry only after mret restores MIE
    bus.csr_mstatus = 32'h0000_0008;
    global_int_en_i = 1'b1;
    int_flag_i = 8'h01;
    inst_addr_i = 32'h0000_0900;
    run_entry(32'h900, C_INT, 32'h80, 32'h800);
    check("handler_no_reentry", hold_flag_o, 0);
    step();
    check("handler_no_write", bus.we_o, 0);
    check("handler_hold", hold_flag_o, 0);
    bus.csr_mepc = 32'h0000_0900;
    inst_i = C_MRET;
    inst_addr_i = 32'h0000_0804;
    #1;
    check("ret_hold_T", hold_flag_o, 1);
    step();
    inst_i = C_NOP;
    inst_addr_i = 32'h0000_0904;
    check("ret_data", bus.data_o, 32'h88);
    bus.csr_mstatus = 32'h0000_0088;
    global_int_en_i = 1'b1;
    step();
    check("ret_strobe", int_assert_o, 1);
    check("ret_target", int_addr_o, 32'h900);
    step();
    run_entry(32'h904, C_INT, 32'h80, 32'h800);
    int_flag_i = 8'h00;
    check("final_hold", hold_flag_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
